// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, operand stack depth and pop encoding.
package cpu_pkg;

    localparam int WORD_W      = 16;
    localparam int STACK_DEPTH = 16;

    typedef enum logic [1:0] {
        POP_NONE = 2'd0,
        POP_ONE  = 2'd1,
        POP_TWO  = 2'd2
    } pop_t;

    localparam logic [1:0] POP_ILLEGAL = 2'd3;

endpackage

// File: rtl/stack_mem.sv
// Operand stack storage: one synchronous write port, two combinational reads.
module stack_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are qualified by the count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata0 = mem_q[raddr0];
    assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/data_stack.sv
// Operand stack feeding the ALU; single-cycle pop/push with sticky error.
// Optional high-water mark output enabled by DATA_STACK_MAX_COUNT_EN.
module data_stack
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = STACK_DEPTH,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [1:0]       pop,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] stk0,
    output logic [WIDTH-1:0] stk1,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             err,
    output logic [CW-1:0]    max_count
);

    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;
    logic [CW:0]      sum_w;
    logic             illegal, under, over, accept, we;
    logic [AW-1:0]    waddr, raddr0, raddr1;
    logic [WIDTH-1:0] rdata0, rdata1;

    // One extra bit keeps count - pop + push from wrapping.
    assign sum_w   = {1'b0, count_q} - (CW + 1)'(pop) + (CW + 1)'(push);
    assign illegal = (pop == POP_ILLEGAL);
    assign under   = (CW'(pop) > count_q);
    assign over    = (sum_w > (CW + 1)'(DEPTH));
    assign waddr   = count_q[AW-1:0] - AW'(pop);
    assign raddr0  = count_q[AW-1:0] - AW'(1);
    assign raddr1  = count_q[AW-1:0] - AW'(2);

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        accept  = 1'b0;
        we      = 1'b0;
        if (flush) begin
            count_d = '0;
            err_d   = 1'b0;
        end else if (illegal || under || over) begin
            err_d = 1'b1;
        end else begin
            accept  = 1'b1;
            count_d = sum_w[CW-1:0];
            we      = push;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (we),
        .waddr  (waddr),
        .wdata  (push_data),
        .raddr0 (raddr0),
        .raddr1 (raddr1),
        .rdata0 (rdata0),
        .rdata1 (rdata1)
    );

`ifdef DATA_STACK_MAX_COUNT_EN
    logic [CW-1:0] max_q, max_d;

    always_comb begin
        max_d = max_q;
        if (flush) begin
            max_d = '0;
        end else if (accept && (count_d > max_q)) begin
            max_d = count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign max_count = max_q;
`else
    assign max_count = '0;
`endif

    assign count = count_q;
    assign err   = err_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign stk0  = (count_q != '0) ? rdata0 : '0;
    assign stk1  = (count_q >= CW'(2)) ? rdata1 : '0;

endmodule

// File: tb/tb_data_stack.sv
// Directed, table-driven bench for the operand stack.
module tb_data_stack;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    pop = 2'd0;
    logic          push = 1'b0;
    logic [W-1:0]  push_data = '0;
    logic [W-1:0]  stk0, stk1;
    logic [CW-1:0] count, max_count;
    logic          empty, full, err;

    int n_total = 0;
    int n_pass  = 0;
    int mc_model = 0;

    data_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .pop       (pop),
        .push      (push),
        .push_data (push_data),
        .stk0      (stk0),
        .stk1      (stk1),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .err       (err),
        .max_count (max_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         f;
        logic [1:0]   p;
        logic         pu;
        logic [15:0]  d;
        int           c;
        logic [15:0]  s0;
        logic [15:0]  s1;
        logic         e;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int exp_max();
`ifdef DATA_STACK_MAX_COUNT_EN
        return mc_model;
`else
        return 0;
`endif
    endfunction

    task automatic step(input string tag, input logic f, input logic [1:0] p,
                        input logic pu, input logic [15:0] d, input int c,
                        input logic [15:0] s0, input logic [15:0] s1,
                        input logic e);
        flush = f; pop = p; push = pu; push_data = d;
        @(posedge clk);
        #1;
        if (f) mc_model = 0;
        else if (c > mc_model) mc_model = c;
        chk({tag, " count"}, int'(count), c);
        chk({tag, " stk0"}, int'(stk0), int'(s0));
        chk({tag, " stk1"}, int'(stk1), int'(s1));
        chk({tag, " err"}, int'(err), int'(e));
        chk({tag, " empty"}, int'(empty), int'(c == 0));
        chk({tag, " full"}, int'(full), int'(c == D));
        chk({tag, " max"}, int'(max_count), exp_max());
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1'b0, 2'd0, 1'b1, 16'hDEAD, 1, 16'hDEAD, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 2'd0, 1'b1, 16'hBEEF, 2, 16'hBEEF, 16'hDEAD, 1'b0};
        tbl[2] = '{1'b0, 2'd2, 1'b1, 16'h9200, 1, 16'h9200, 16'h0000, 1'b0};
        tbl[3] = '{1'b0, 2'd1, 1'b0, 16'h0000, 0, 16'h0000, 16'h0000, 1'b0};
        tbl[4] = '{1'b0, 2'd1, 1'b0, 16'h0000, 0, 16'h0000, 16'h0000, 1'b1};
        tbl[5] = '{1'b0, 2'd0, 1'b1, 16'h0001, 1, 16'h0001, 16'h0000, 1'b1};
        tbl[6] = '{1'b1, 2'd1, 1'b1, 16'h5555, 0, 16'h0000, 16'h0000, 1'b0};
        tbl[7] = '{1'b0, 2'd0, 1'b0, 16'h7777, 0, 16'h0000, 16'h0000, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset count", int'(count), 0);
        chk("reset err", int'(err), 0);
        chk("reset empty", int'(empty), 1);
        chk("reset stk0", int'(stk0), 0);
        chk("reset max", int'(max_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step($sformatf("vec%0d", i), tbl[i].f, tbl[i].p, tbl[i].pu,
                 tbl[i].d, tbl[i].c, tbl[i].s0, tbl[i].s1, tbl[i].e);
        end

        for (int i = 0; i < 16; i++) begin
            step($sformatf("fill%0d", i), 1'b0, 2'd0, 1'b1, 16'(i), i + 1,
                 16'(i), (i == 0) ? 16'h0 : 16'(i - 1), 1'b0);
        end
        step("ovf", 1'b0, 2'd0, 1'b1, 16'h1234, 16, 16'h000F, 16'h000E, 1'b1);
        step("replace", 1'b0, 2'd1, 1'b1, 16'hCAFE, 16, 16'hCAFE, 16'h000E, 1'b1);
        step("pop2", 1'b0, 2'd2, 1'b0, 16'h0, 14, 16'h000D, 16'h000C, 1'b1);
        step("flush2", 1'b1, 2'd0, 1'b0, 16'h0, 0, 16'h0, 16'h0, 1'b0);

        step("p1", 1'b0, 2'd0, 1'b1, 16'h0011, 1, 16'h0011, 16'h0, 1'b0);
        step("p2", 1'b0, 2'd0, 1'b1, 16'h0022, 2, 16'h0022, 16'h0011, 1'b0);
        step("p3", 1'b0, 2'd0, 1'b1, 16'h0033, 3, 16'h0033, 16'h0022, 1'b0);
        step("pop3", 1'b0, 2'd3, 1'b1, 16'hAAAA, 3, 16'h0033, 16'h0022, 1'b1);
        step("under2", 1'b0, 2'd2, 1'b0, 16'h0, 1, 16'h0011, 16'h0, 1'b1);
        step("under3", 1'b0, 2'd2, 1'b1, 16'hBBBB, 1, 16'h0011, 16'h0, 1'b1);

        #2;
        rst_n = 1'b0;
        #1;
        mc_model = 0;
        chk("async count", int'(count), 0);
        chk("async stk0", int'(stk0), 0);
        chk("async err", int'(err), 0);
        chk("async max", int'(max_count), 0);
        @(negedge clk);
        flush = 1'b0; pop = 2'd0; push = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step($sformatf("mc%0d", i), 1'b0, 2'd0, 1'b1, 16'(16'h100 + i),
                 i + 1, 16'(16'h100 + i), (i == 0) ? 16'h0 : 16'(16'hFF + i), 1'b0);
        end
        step("mcpop2", 1'b0, 2'd2, 1'b0, 16'h0, 3, 16'h0102, 16'h0101, 1'b0);
        step("mcpop1", 1'b0, 2'd1, 1'b0, 16'h0, 2, 16'h0101, 16'h0100, 1'b0);
`ifdef DATA_STACK_MAX_COUNT_EN
        chk("mc hold 5", int'(max_count), 5);
`else
        chk("mc tied 0", int'(max_count), 0);
`endif
        step("mcflush", 1'b1, 2'd0, 1'b0, 16'h0, 0, 16'h0, 16'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_stack.md
Name: data_stack

Overview:
- Operand stack of the stack-machine CPU, directly upstream of the ALU.
- Holds evaluation-stack entries and drives the two ALU operands combinationally:
  - stk1 (second entry) feeds ALU a.
  - stk0 (top entry) feeds ALU b.
- Typical binary ALU instruction: pop two, push the ALU result, all in one cycle. Single-cycle push/pop with sticky error reporting.

Parameters:
- WIDTH, 16, entry width; must match the ALU operand width.
- DEPTH, 16, number of entries; power of two, minimum 4.
- CW, $clog2(DEPTH+1), count width (localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear: count to 0, err to 0.
- pop  in  2  entries removed this cycle: 0, 1 or 2; value 3 is illegal.
- push  in  1  push push_data after the pop.
- push_data  in  WIDTH  value pushed (normally the ALU out).
- stk0  out  WIDTH  top entry; 0 when count==0.
- stk1  out  WIDTH  second entry; 0 when count<2.
- count  out  CW  number of valid entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- err  out  1  sticky underflow/overflow/illegal-pop flag.
- max_count  out  CW  high-water mark (optional feature).

Behaviour:
- Reset (async assert, sync-free release):
  - count=0, err=0, max_count=0.
  - Storage contents need no reset.
  - stk0/stk1 read 0 through the count gating.
- Outputs:
  - stk0, stk1, empty, full are combinational from registered state.
  - Effect of an operation is visible the cycle after the clock edge.
  - ALU result combinationally from stk0/stk1 back to push_data is legal; no path from pop/push to any output.
- Per edge, priority order:
  1. flush=1: count<=0, err<=0; pop/push ignored.
  2. pop==3: illegal; no state change; err<=1.
  3. pop>count: underflow; whole operation suppressed, including the push; err<=1.
  4. count-pop+push>DEPTH: overflow; whole operation suppressed; err<=1.
  5. Otherwise: count<=count-pop+push; if push, mem[count-pop]<=push_data.
- Entry indexing: entry i (0=bottom) at mem[i]; stk0=mem[count-1], stk1=mem[count-2].
- Boundary cases:
  - Pop 2 + push at count==2: result lands in mem[0], count=1.
  - Push with pop=1 at full: legal, replaces the top.
  - Push at full with pop=0: overflow.
  - pop=0 and push=0: no-op; err holds.
- err clears only on reset or flush.
- count arithmetic is done in CW+1 bits so no wrap occurs; count never leaves 0..DEPTH.
- Reset mid-operation: state returns immediately to reset values; the pending operation is lost.

Optional Feature:
- Macro: DATA_STACK_MAX_COUNT_EN.
- Defined:
  - max_count tracks the maximum count reached since reset or flush.
  - Updated in the same edge as count, so the new max is visible next cycle.
  - Suppressed operations do not update it.
  - flush sets it to 0.
- Undefined: max_count tied to 0, no register inferred.

Decomposition:
- Package cpu_pkg:
  - WORD_W=16, STACK_DEPTH=16.
  - typedef enum logic [1:0] pop_t {POP_NONE=0, POP_ONE=1, POP_TWO=2}.
- Sub-module stack_mem:
  - DEPTH x WIDTH register file, one synchronous write port, two combinational read ports.
  - Holds no control logic.
- data_stack holds the count, legality checks, err, max_count and output gating.

Test Plan:
- Reset, then push 0xDEAD, then push 0xBEEF -> stk1=0xDEAD, stk0=0xBEEF, count=2, err=0.
- From that state, pop=2, push=1, push_data=0x9200 -> next cycle count=1, stk0=0x9200, stk1=0, empty=0.
- Pop=1 at count=0 -> count stays 0, err=1; then push 0x0001 -> count=1, err still 1; flush -> count=0, err=0.
- Push 16 values 0x0000..0x000F -> full=1, stk0=0x000F; then push 0x1234 -> count=16, stk0=0x000F, err=1; then pop=1 with push 0xCAFE -> stk0=0xCAFE, count=16.
- pop=3 with push at count=3 -> no change, err=1; assert rst_n low mid-cycle -> count=0, stk0=0 immediately, without waiting for a clock edge.
- DATA_STACK_MAX_COUNT_EN defined: push 5, pop 3 -> max_count=5, count=2; flush -> max_count=0. Undefined: max_count=0 throughout.
